intra_ang_param_gen: RTL and testbench

Parametrised angular-prediction parameter generator for the HEVC intra path. It accepts one (mode, block size) request and resolves intraPredAngle, invAngle, direction and the 0..17 angle class. It then streams the per-row reference offset (iIdx) and interpolation weight (iFact) for every row of the block, LANES rows per beat, under a valid/ready handshake. It sits between the intra mode decision and the reference-sample interpolation datapath.

---
 rtl/intra_ang_param_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_intra_ang_param_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/intra_ang_param_gen.sv
// rtl/intra_ang_param_gen.sv - HEVC intra angular parameter generator (angle, invAngle, per-row iIdx/iFact)
module intra_ang_param_gen #(
  parameter int MAX_LOG2_SIZE = 5,
  parameter int LANES         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [5:0]           req_mode,
  input  logic [2:0]           req_log2size,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [6:0]           out_angle,
  output logic [12:0]          out_inv_angle,
  output logic [4:0]           out_ang_idx,
  output logic                 out_is_vert,
  output logic [4:0]           out_row_base,
  output logic [LANES*7-1:0]   out_idx,
  output logic [LANES*5-1:0]   out_fact,
  output logic                 out_last,
  output logic                 out_err
);

  localparam int CW      = MAX_LOG2_SIZE;
  localparam int LANE_SH = (LANES == 4) ? 2 : ((LANES == 2) ? 1 : 0);

  typedef enum logic {IDLE, RUN} state_t;

  // intraPredAngle for the angular modes; non-angular / out-of-range modes map to 0
  function automatic logic [6:0] angle_of(input logic [5:0] mode);
    logic [6:0] a;
    case (mode)
      6'd2:    a = 7'sd32;
      6'd3:    a = 7'sd26;
      6'd4:    a = 7'sd21;
      6'd5:    a = 7'sd17;
      6'd6:    a = 7'sd13;
      6'd7:    a = 7'sd9;
      6'd8:    a = 7'sd5;
      6'd9:    a = 7'sd2;
      6'd10:   a = 7'sd0;
      6'd11:   a = -7'sd2;
      6'd12:   a = -7'sd5;
      6'd13:   a = -7'sd9;
      6'd14:   a = -7'sd13;
      6'd15:   a = -7'sd17;
      6'd16:   a = -7'sd21;
      6'd17:   a = -7'sd26;
      6'd18:   a = -7'sd32;
      6'd19:   a = -7'sd26;
      6'd20:   a = -7'sd21;
      6'd21:   a = -7'sd17;
      6'd22:   a = -7'sd13;
      6'd23:   a = -7'sd9;
      6'd24:   a = -7'sd5;
      6'd25:   a = -7'sd2;
      6'd26:   a = 7'sd0;
      6'd27:   a = 7'sd2;
      6'd28:   a = 7'sd5;
      6'd29:   a = 7'sd9;
      6'd30:   a = 7'sd13;
      6'd31:   a = 7'sd17;
      6'd32:   a = 7'sd21;
      6'd33:   a = 7'sd26;
      6'd34:   a = 7'sd32;
      default: a = 7'sd0;
    endcase
    return a;
  endfunction

  // invAngle is only defined for negative angles; everything else reads as 0
  function automatic logic [12:0] inv_of(input logic [6:0] a);
    logic [12:0] v;
    case (a)
      -7'sd2:  v = 13'h1000;
      -7'sd5:  v = -13'sd1638;
      -7'sd9:  v = -13'sd910;
      -7'sd13: v = -13'sd630;
      -7'sd17: v = -13'sd482;
      -7'sd21: v = -13'sd390;
      -7'sd26: v = -13'sd315;
      -7'sd32: v = -13'sd256;
      default: v = 13'd0;
    endcase
    return v;
  endfunction

  // Angle class: negative magnitudes ascend 0..7, zero is 8, positives 9..16
  function automatic logic [4:0] class_of(input logic [6:0] a);
    logic [4:0] c;
    case (a)
      -7'sd2:  c = 5'd0;
      -7'sd5:  c = 5'd1;
      -7'sd9:  c = 5'd2;
      -7'sd13: c = 5'd3;
      -7'sd17: c = 5'd4;
      -7'sd21: c = 5'd5;
      -7'sd26: c = 5'd6;
      -7'sd32: c = 5'd7;
      7'sd0:   c = 5'd8;
      7'sd2:   c = 5'd9;
      7'sd5:   c = 5'd10;
      7'sd9:   c = 5'd11;
      7'sd13:  c = 5'd12;
      7'sd17:  c = 5'd13;
      7'sd21:  c = 5'd14;
      7'sd26:  c = 5'd15;
      7'sd32:  c = 5'd16;
      default: c = 5'd17;
    endcase
    return c;
  endfunction

  state_t          state, state_nxt;
  logic [6:0]      angle_q;
  logic [12:0]     inv_q;
  logic [4:0]      class_q;
  logic            vert_q;
  logic            err_q;
  logic [2:0]      log2_q;
  logic [CW-1:0]   beat_q;

  logic            req_bad;
  logic [6:0]      req_angle;
  logic            accept;
  logic            is_last;
  logic [CW:0]     beats_w;
  logic [CW:0]     last_w;
  logic [7:0]      row_w;
  logic signed [12:0] ang_s;

  // Decode the incoming request: legality and table lookup
  always_comb begin
    req_bad   = (req_mode < 6'd2) || (req_mode > 6'd34) ||
                (req_log2size < 3'd2) || (req_log2size > 3'(MAX_LOG2_SIZE));
    req_angle = req_bad ? 7'd0 : angle_of(req_mode);
  end

  // Final beat index of the current block: (N / LANES) - 1
  always_comb begin
    beats_w = {{CW{1'b0}}, 1'b1} << (log2_q - 3'(LANE_SH));
    last_w  = beats_w - {{CW{1'b0}}, 1'b1};
  end

  assign is_last = err_q || ({1'b0, beat_q} == last_w);
  assign accept  = req_valid && req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; req_ready is held low while reset is asserted
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        out_valid = 1'b1;
        if (out_ready && is_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-block parameters are captured on acceptance and held for the whole block
  always_ff @(posedge clk) begin
    if (rst) begin
      angle_q <= '0;
      inv_q   <= '0;
      class_q <= '0;
      vert_q  <= 1'b0;
      err_q   <= 1'b0;
      log2_q  <= '0;
      beat_q  <= '0;
    end else if (accept) begin
      angle_q <= req_angle;
      inv_q   <= req_bad ? 13'd0 : inv_of(req_angle);
      class_q <= req_bad ? 5'd17 : class_of(req_angle);
      vert_q  <= !req_bad && (req_mode >= 6'd18);
      err_q   <= req_bad;
      log2_q  <= req_log2size;
      beat_q  <= '0;
    end else if (out_valid && out_ready && !is_last) begin
      beat_q  <= beat_q + CW'(1);
    end
  end

  assign row_w = 8'(beat_q) << LANE_SH;
  assign ang_s = {{6{angle_q[6]}}, angle_q};

  // One multiplier per lane: t = (y+1)*angle, iIdx = floor(t/32), iFact = t mod 32
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0]         yp1;
    logic signed [12:0] yp1_s;
    logic signed [12:0] prod;

    // Lane product for row y = row_base + k
    always_comb begin
      yp1   = row_w + 8'(k + 1);
      yp1_s = {5'd0, yp1};
      prod  = yp1_s * ang_s;
    end

    assign out_idx[7*k +: 7]  = 7'(prod >>> 5);
    assign out_fact[5*k +: 5] = prod[4:0];
  end

  assign out_angle     = angle_q;
  assign out_inv_angle = inv_q;
  assign out_ang_idx   = class_q;
  assign out_is_vert   = vert_q;
  assign out_err       = err_q;
  assign out_row_base  = row_w[4:0];
  assign out_last      = out_valid && is_last;

endmodule

// File: tb/tb_intra_ang_param_gen.sv
// tb/tb_intra_ang_param_gen.sv - directed self-checking bench for intra_ang_param_gen
`timescale 1ns/1ps
module tb_intra_ang_param_gen;
  localparam int LANES = 4;
  localparam int MAXL  = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [5:0]           req_mode = '0;
  logic [2:0]           req_log2size = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [6:0]           out_angle;
  logic [12:0]          out_inv_angle;
  logic [4:0]           out_ang_idx;
  logic                 out_is_vert;
  logic [4:0]           out_row_base;
  logic [LANES*7-1:0]   out_idx;
  logic [LANES*5-1:0]   out_fact;
  logic                 out_last;
  logic                 out_err;

  int n_checks = 0;
  int n_errors = 0;

  int ang_tbl [35] = '{0, 0, 32, 26, 21, 17, 13, 9, 5, 2, 0, -2, -5, -9, -13, -17, -21, -26, -32,
                       -26, -21, -17, -13, -9, -5, -2, 0, 2, 5, 9, 13, 17, 21, 26, 32};
  int mags [8] = '{2, 5, 9, 13, 17, 21, 26, 32};

  intra_ang_param_gen #(.MAX_LOG2_SIZE(MAXL), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_log2size(req_log2size),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_angle(out_angle), .out_inv_angle(out_inv_angle),
    .out_ang_idx(out_ang_idx), .out_is_vert(out_is_vert),
    .out_row_base(out_row_base), .out_idx(out_idx), .out_fact(out_fact),
    .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_inv(input int a);
    case (a)
      -2:  return -4096;
      -5:  return -1638;
      -9:  return -910;
      -13: return -630;
      -17: return -482;
      -21: return -390;
      -26: return -315;
      -32: return -256;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_class(input int a);
    if (a == 0) return 8;
    for (int i = 0; i < 8; i++) begin
      if (a == -mags[i]) return i;
      if (a == mags[i]) return 9 + i;
    end
    return 17;
  endfunction

  function automatic int floor32(input int t);
    if (t >= 0) return t / 32;
    return -((-t + 31) / 32);
  endfunction

  task automatic check_beat(input int mode, input int lg, input int b, input int nb);
    bit legal;
    int a, y, t, fi;
    legal = (mode >= 2) && (mode <= 34) && (lg >= 2) && (lg <= MAXL);
    a = legal ? ang_tbl[mode] : 0;
    check("valid", out_valid, 1);
    check("err", out_err, legal ? 0 : 1);
    check("last", out_last, (b == nb - 1) ? 1 : 0);
    check("angle", $signed(out_angle), a);
    check("inv", $signed(out_inv_angle), legal ? exp_inv(a) : 0);
    check("ang_idx", out_ang_idx, legal ? exp_class(a) : 17);
    check("is_vert", out_is_vert, (legal && mode >= 18) ? 1 : 0);
    check("row_base", out_row_base, b * LANES);
    for (int k = 0; k < LANES; k++) begin
      y  = b * LANES + k;
      t  = (y + 1) * a;
      fi = floor32(t);
      check($sformatf("idx_b%0d_l%0d", b, k), $signed(out_idx[7*k +: 7]), fi);
      check($sformatf("fact_b%0d_l%0d", b, k), out_fact[5*k +: 5], t - fi * 32);
    end
  endtask

  task automatic send_req(input int mode, input int lg);
    check("req_ready_idle", req_ready, 1);
    check("valid_idle", out_valid, 0);
    req_valid    = 1'b1;
    req_mode     = 6'(mode);
    req_log2size = 3'(lg);
    @(negedge clk);
    req_valid    = 1'b0;
    req_mode     = 6'($urandom_range(0, 63));
    req_log2size = 3'($urandom_range(0, 7));
    check("latency_valid", out_valid, 1);
  endtask

  task automatic run_block(input int mode, input int lg, input bit stall);
    int nb, b, guard;
    bit legal;
    legal = (mode >= 2) && (mode <= 34) && (lg >= 2) && (lg <= MAXL);
    nb = legal ? (1 << lg) / LANES : 1;
    b = 0;
    guard = 0;
    send_req(mode, lg);
    while (b < nb && guard < 500) begin
      check_beat(mode, lg, b, nb);
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_ready) b++;
      guard++;
    end
    out_ready = 1'b0;
    check("beats_done", b, nb);
    check("valid_after", out_valid, 0);
    check("ready_after", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] e_idx;
    logic [19:0] e_fact;

    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_angle", out_angle, 0);
    check("rst_ang_idx", out_ang_idx, 0);
    check("rst_idx", int'(out_idx), 0);
    check("rst_fact", int'(out_fact), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    run_block(26, 2, 1'b0);
    run_block(2, 3, 1'b0);

    send_req(13, 2);
    e_idx  = {7'h7e, 7'h7f, 7'h7f, 7'h7f};
    e_fact = {5'd28, 5'd5, 5'd14, 5'd23};
    check("m13_angle", $signed(out_angle), -9);
    check("m13_inv", $signed(out_inv_angle), -910);
    check("m13_ang_idx", out_ang_idx, 2);
    check("m13_idx", int'(out_idx), int'(e_idx));
    check("m13_fact", int'(out_fact), int'(e_fact));
    check("m13_last", out_last, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("m13_done", out_valid, 0);

    run_block(13, 2, 1'b1);
    run_block(30, 5, 1'b1);
    run_block(1, 2, 1'b0);
    run_block(20, 6, 1'b0);
    run_block(35, 3, 1'b0);
    run_block(10, 1, 1'b0);

    send_req(30, 5);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_row_base", out_row_base, 12);
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", req_ready, 0);
    check("midrst_last", out_last, 0);
    check("midrst_angle", out_angle, 0);
    check("midrst_idx", int'(out_idx), 0);
    check("midrst_row_base", out_row_base, 0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", req_ready, 1);
    check("postrst_valid", out_valid, 0);

    run_block(18, 3, 1'b0);
    run_block(34, 4, 1'b1);
    run_block(9, 5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
